// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by core stores, serializer FSM,
// and a 32-bit status word for the core's UART CSR.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [7:0]  wr_data,
  input  logic        ovf_clr,
  output logic [31:0] csr,
  output logic        tx
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  baud_cnt_q, baud_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [31:0]       csr_q, csr_d;

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [7:0]        mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;

  logic              full_c;
  logic              empty_c;
  logic              push_c;
  logic              pop_c;
  logic              baud_end_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_c     = (count_q == OCC_W'(FIFO_DEPTH));
  assign empty_c    = (count_q == '0);
  assign push_c     = wr_en & ~full_c;
  assign baud_end_c = (baud_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  // Serializer: next state, baud/bit counters, shift register and FIFO pop request
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        baud_cnt_d = '0;
        if (!empty_c) begin
          pop_c   = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
          state_d    = S_DATA;
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift_q[7:1]};
          bit_idx_d  = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end_c) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued
          if (!empty_c) begin
            pop_c   = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d    = S_IDLE;
        baud_cnt_d = '0;
      end
    endcase
  end

  // FIFO bookkeeping and sticky overflow; a store into a full FIFO is dropped even if a pop frees a slot
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push_c) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_c) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end

    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_en && full_c) begin
      ovf_d = 1'b1;
    end
  end

  // Registered outputs derived from the post-edge state
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    csr_d = {16'h0000,
             8'(count_d),
             4'h0,
             ovf_d,
             (count_d == '0),
             (count_d == OCC_W'(FIFO_DEPTH)),
             (state_d != S_IDLE)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      tx_q       <= 1'b1;
      csr_q      <= 32'h0000_0004;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      tx_q       <= tx_d;
      csr_q      <= csr_d;
    end
  end

  // Storage needs no reset: entries are only read after being written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign tx  = tx_q;
  assign csr = csr_q;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_mmio;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [7:0]  wr_data;
  logic        ovf_clr;
  logic [31:0] csr;
  logic        tx;

  int n_checks;
  int n_fail;

  logic [8:0]  rx_q [$];
  int          start_cyc [$];
  int          cyc;
  bit          mon_active;
  int          mon_pos;
  logic [7:0]  mon_byte;
  logic        mon_stop;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .ovf_clr(ovf_clr),
    .csr    (csr),
    .tx     (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Line receiver: samples mid-bit on the falling clock edge, records {stop, byte}
  always @(negedge clk) begin
    cyc++;
    if (rst === 1'b1) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (tx === 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_byte   = 8'h00;
        mon_stop   = 1'b0;
        start_cyc.push_back(cyc);
      end
    end else begin
      mon_pos++;
      if ((mon_pos % CPB) == (CPB / 2) && mon_pos >= CPB && mon_pos < 9 * CPB)
        mon_byte[mon_pos / CPB - 1] = tx;
      if (mon_pos == 9 * CPB + CPB / 2)
        mon_stop = tx;
      if (mon_pos == 10 * CPB - 1) begin
        mon_active = 1'b0;
        rx_q.push_back({mon_stop, mon_byte});
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_rx();
    rx_q.delete();
    start_cyc.delete();
  endtask

  // Checks every cycle of one frame, starting at the first start-bit cycle
  task automatic chk_frame(input string tag, input logic [7:0] b);
    logic exp;
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i < CPB)            exp = 1'b0;
      else if (i >= 9 * CPB)  exp = 1'b1;
      else                    exp = b[i / CPB - 1];
      check_eq($sformatf("%s_c%0d", tag, i), {31'd0, tx}, {31'd0, exp});
      step();
    end
  endtask

  task automatic wait_rx(input int n, input int budget);
    int c;
    c = 0;
    while (rx_q.size() < n && c < budget) begin
      step();
      c++;
    end
    check_eq("rx_wait", rx_q.size(), n);
  endtask

  initial begin
    int lows;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    ovf_clr  = 1'b0;

    // Reset values
    step();
    step();
    check_eq("rst_tx", {31'd0, tx}, 32'd1);
    check_eq("rst_csr", csr, 32'h0000_0004);
    rst = 1'b0;
    step();
    check_eq("idle_csr", csr, 32'h0000_0004);

    // Single byte 0x55
    clear_rx();
    wr_en = 1'b1; wr_data = 8'h55;
    step();
    wr_en = 1'b0;
    check_eq("acc_csr", csr, 32'h0000_0100);
    check_eq("acc_tx", {31'd0, tx}, 32'd1);
    step();
    check_eq("pop_csr", csr, 32'h0000_0005);
    chk_frame("f55", 8'h55);
    check_eq("f55_done_csr", csr, 32'h0000_0004);
    check_eq("f55_rx_n", rx_q.size(), 1);
    if (rx_q.size() > 0) check_eq("f55_rx", {23'd0, rx_q[0]}, 32'h0000_0155);

    // Back-to-back 0xA5, 0x3C
    clear_rx();
    wr_en = 1'b1; wr_data = 8'hA5;
    step();
    wr_data = 8'h3C;
    step();
    wr_en = 1'b0;
    check_eq("b2b_csr", csr, 32'h0000_0101);
    chk_frame("fA5", 8'hA5);
    chk_frame("f3C", 8'h3C);
    check_eq("b2b_done_csr", csr, 32'h0000_0004);
    check_eq("b2b_rx_n", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      check_eq("b2b_rx0", {23'd0, rx_q[0]}, 32'h0000_01A5);
      check_eq("b2b_rx1", {23'd0, rx_q[1]}, 32'h0000_013C);
      check_eq("b2b_gap", start_cyc[1] - start_cyc[0], 10 * CPB);
    end

    // Overflow: six writes, 0x06 dropped
    clear_rx();
    for (int i = 1; i <= 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(i);
      step();
      if (i == 5) check_eq("ovf_full_csr", csr, 32'h0000_0403);
      if (i == 6) check_eq("ovf_set_csr", csr, 32'h0000_040B);
    end
    wr_en = 1'b0;
    wait_rx(5, 400);
    for (int i = 0; i < 60; i++) step();
    check_eq("ovf_rx_n", rx_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < rx_q.size())
        check_eq($sformatf("ovf_rx%0d", i), {23'd0, rx_q[i]}, 32'h100 + 32'(i + 1));
    check_eq("ovf_idle_csr", csr, 32'h0000_000C);

    // Overflow clear, then clear racing a new overflow
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check_eq("ovfclr_csr", csr, 32'h0000_0004);
    clear_rx();
    for (int i = 1; i <= 5; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h10 + i);
      step();
    end
    check_eq("ovf2_full_csr", csr, 32'h0000_0403);
    wr_data = 8'h99; ovf_clr = 1'b1;
    step();
    wr_en = 1'b0; ovf_clr = 1'b0;
    check_eq("ovf_set_wins", csr, 32'h0000_040B);
    wait_rx(5, 400);
    for (int i = 0; i < 60; i++) step();
    if (rx_q.size() > 4) check_eq("ovf2_rx4", {23'd0, rx_q[4]}, 32'h0000_0115);
    check_eq("ovf2_idle_csr", csr, 32'h0000_000C);

    // Reset during DATA bit 3 with two bytes queued
    clear_rx();
    wr_en = 1'b1; wr_data = 8'hC3;
    step();
    wr_data = 8'h5A;
    step();
    wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    check_eq("rmf_q_csr", csr, 32'h0000_0209);
    for (int i = 0; i < 16; i++) step();
    check_eq("rmf_bit3", {31'd0, tx}, 32'd0);
    rst = 1'b1;
    step();
    check_eq("rmf_tx", {31'd0, tx}, 32'd1);
    check_eq("rmf_csr", csr, 32'h0000_0004);
    step();
    rst = 1'b0;
    clear_rx();
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tx !== 1'b1) lows++;
    end
    check_eq("rmf_line_idle", lows, 0);
    check_eq("rmf_no_frames", start_cyc.size(), 0);
    check_eq("rmf_end_csr", csr, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter that sits directly downstream of the RV32I core's UART I/O registers. Core stores to the UART data register push bytes into a small transmit FIFO. The block serializes each byte as 8N1 on `tx`, LSB first, and returns a 32-bit status word that the core reads back through its UART CSR register.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 104: clock cycles per serial bit; must be ≥ 2.
- `FIFO_DEPTH`, default 8: transmit FIFO entries; must be a power of 2, ≤ 128.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `wr_en` in 1: one-cycle strobe for a core store to the UART data register.
- `wr_data` in 8: byte to transmit, qualified by `wr_en`.
- `ovf_clr` in 1: one-cycle strobe that clears the sticky overflow flag.
- `csr` out 32: status word.
  - bit0: tx_busy.
  - bit1: fifo_full.
  - bit2: fifo_empty.
  - bit3: overflow (sticky).
  - bits[15:8]: FIFO occupancy count.
  - all other bits: 0.
- `tx` out 1: serial line, idle high, registered output.

## Operation
- **FIFO:** circular buffer with write/read pointers and an occupancy count of width $clog2(FIFO_DEPTH+1).
  - Push when `wr_en` is high and the FIFO is not full.
  - `full`, `empty` and `count` are evaluated on the state before the edge.
- **Overflow:** `wr_en` while full drops the byte, leaves FIFO contents unchanged, and sets overflow.
  - This holds even if a pop occurs in the same cycle.
- **Simultaneous push and pop when not full:** both happen; count is unchanged.
- **Overflow flag priority:** if `ovf_clr` and a new overflow event occur in the same cycle, set wins.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:** `tx`=1. If the FIFO is non-empty:
  - pop the head into an 8-bit shift register;
  - clear the baud counter;
  - go to START.
- **START:** `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- **DATA:** `tx`=shift[0] for CLKS_PER_BIT cycles per bit.
  - At the end of each bit, shift right and increment the bit index.
  - After bit index 7 completes, go to STOP.
- **STOP:** `tx`=1 for CLKS_PER_BIT cycles. At the end of STOP:
  - if the FIFO is non-empty, pop and go directly to START, with no idle gap;
  - otherwise go to IDLE.
- **Baud counter:** counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary, and is held at 0 in IDLE.
- **tx_busy:** equals (state != IDLE).
- **Writes during transmission:** accepted normally. The in-flight frame is never altered.

## Timing
- **Reset values:**
  - `tx`=1;
  - state IDLE;
  - FIFO empty, pointers 0, count 0;
  - overflow 0;
  - `csr`=0x00000004.
- **Reset mid-frame:** aborts the frame and discards the FIFO; `tx`=1 from the first cycle after the reset edge.
- **Latency:** `wr_en` sampled at edge k into an empty FIFO while IDLE:
  - the byte is in the FIFO after edge k (count=1);
  - it is popped at edge k+1, and `tx` falls after edge k+1.
- **Frame length:** exactly 10·CLKS_PER_BIT cycles from the `tx` falling edge to the end of the stop bit.
- **csr timing:** registered state; reflects a push or pop one cycle after the edge that performs it.
- **Back-to-back frames:** the next start bit begins the cycle after the last stop-bit cycle.

## Test plan
All scenarios use CLKS_PER_BIT=4, FIFO_DEPTH=4.

- **Reset values:** assert `rst` for 2 cycles → `tx`=1, `csr`=0x00000004.
- **Single byte:** write 0x55 while idle.
  - `tx` low 1 cycle after the accepting edge and held 4 cycles.
  - Data bits 1,0,1,0,1,0,1,0, each held 4 cycles, then stop high for 4 cycles (40 cycles total).
  - `csr` bit0 returns to 0 afterwards.
- **Back-to-back frames:** write 0xA5 then 0x3C on consecutive cycles.
  - Two contiguous 40-cycle frames, with no idle cycle between the stop bit of 0xA5 and the start bit of 0x3C.
  - Decoded bytes are 0xA5, 0x3C.
- **Overflow:** 6 consecutive writes 0x01..0x06 while idle.
  - 0x01 is popped the cycle after entry; 0x02–0x05 fill the FIFO (`csr`[15:8]=4, bit1=1).
  - 0x06 is dropped and bit3=1.
  - Exactly 0x01..0x05 are transmitted in order.
- **Overflow clear:** pulse `ovf_clr` → bit3=0. Pulse `ovf_clr` in the same cycle as a write to the full FIFO → bit3 stays 1.
- **Reset mid-frame:** assert `rst` during DATA bit 3 of a frame with 2 bytes queued.
  - `tx`=1 the next cycle and `csr`=0x00000004.
  - No further frames are emitted.
